fifo_singleclock_fwft: RTL



---
 rtl/fifo_pkg.sv | 18 +
 rtl/fifo_ram_dp.sv | 43 ++++
 rtl/fifo_singleclock_fwft.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the single-clock FIFO family.
//   FIFO_READ_STD / FIFO_READ_FWFT : values for the FWFT parameter of the top.
//   fifo_count_width(depth)        : width of a 0..depth occupancy counter.
// -----------------------------------------------------------------------------
package fifo_pkg;

  localparam int FIFO_READ_STD  = 0;
  localparam int FIFO_READ_FWFT = 1;

  // One extra bit over the pointer width so that a completely full FIFO
  // (count == depth) can be told apart from an empty one.
  function automatic int fifo_count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ram_dp.sv
// -----------------------------------------------------------------------------
// fifo_ram_dp
// Simple dual-port storage array: one write port, one synchronous read port
// with read enable. The array and read register carry no reset so the block
// maps onto block RAM.
// Ports:
//   clk      in   clock
//   i_we     in   write enable
//   i_waddr  in   write address
//   i_wdata  in   write data
//   i_re     in   read enable; o_rdata updates only when set
//   i_raddr  in   read address
//   o_rdata  out  registered read data
// -----------------------------------------------------------------------------
module fifo_ram_dp #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/fifo_singleclock_fwft.sv
// -----------------------------------------------------------------------------
// fifo_singleclock_fwft
// Parametrised single-clock FIFO with selectable standard or
// first-word-fall-through read, all DEPTH entries usable, programmable
// almost-full/almost-empty flags and optional sticky error flags.
//
// Optional feature macro: FIFO_ERR_FLAGS_EN
//   defined     : overflow/underflow are sticky, cleared by err_clr.
//   not defined : overflow/underflow tied to 0, err_clr ignored.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   din, wr_en        write data and request
//   full, prog_full   count == DEPTH, count >= PROG_FULL
//   dout, rd_en       read data; read request (standard) or pop (FWFT)
//   empty, prog_empty no word readable, count <= PROG_EMPTY
//   count             words held, 0..DEPTH (FWFT: includes the output word)
//   overflow          sticky: wr_en seen while full
//   underflow         sticky: rd_en seen while empty
//   err_clr           synchronous clear of overflow/underflow
//
// Handshake: a write is accepted on a rising edge where wr_en & ~full; a read
// is accepted where rd_en & ~empty. Requests outside those conditions change
// no data, no pointer and no count (only the sticky error flags).
// -----------------------------------------------------------------------------
module fifo_singleclock_fwft
  import fifo_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 32,
  parameter int PROG_FULL  = DEPTH / 2,
  parameter int PROG_EMPTY = 2,
  parameter int FWFT       = FIFO_READ_STD
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [WIDTH-1:0]                   din,
  input  logic                               wr_en,
  output logic                               full,
  output logic                               prog_full,
  output logic [WIDTH-1:0]                   dout,
  input  logic                               rd_en,
  output logic                               empty,
  output logic                               prog_empty,
  output logic [fifo_count_width(DEPTH)-1:0] count,
  output logic                               overflow,
  output logic                               underflow,
  input  logic                               err_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = fifo_count_width(DEPTH);

  localparam logic [CW-1:0] LP_DEPTH      = CW'(DEPTH);
  localparam logic [CW-1:0] LP_PROG_FULL  = CW'(PROG_FULL);
  localparam logic [CW-1:0] LP_PROG_EMPTY = CW'(PROG_EMPTY);

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $fatal(1, "fifo_singleclock_fwft: DEPTH must be a power of two and at least 2");
    end
  endgenerate

  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_wr_acc;
  logic             w_rd_acc;
  logic             w_ram_re;
  logic             w_empty;
  logic [WIDTH-1:0] w_ram_q;
  logic [WIDTH-1:0] w_dout;

  assign full       = (r_count == LP_DEPTH);
  assign prog_full  = (r_count >= LP_PROG_FULL);
  assign prog_empty = (r_count <= LP_PROG_EMPTY);
  assign count      = r_count;
  assign empty      = w_empty;
  assign dout       = w_dout;

  // A write while full is dropped even if a read frees a slot this cycle.
  assign w_wr_acc = wr_en & ~full;

  // The read pointer follows RAM reads, which in FWFT mode are prefetches
  // rather than pops; count follows accepted writes and accepted pops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_ram_re) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Read and write addresses never collide on an accepted access: a RAM read
  // needs at least one word in the RAM, and a write needs a free slot.
  fifo_ram_dp #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_wr_acc),
    .i_waddr (r_wr_ptr),
    .i_wdata (din),
    .i_re    (w_ram_re),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_ram_q)
  );

  generate
    if (FWFT == FIFO_READ_FWFT) begin : g_fwft
      // The RAM read register is the output stage; r_out_valid says whether
      // it currently holds the head word.
      logic          r_out_valid;
      logic [CW-1:0] w_ram_words;

      assign w_ram_words = r_count - CW'(r_out_valid);
      assign w_rd_acc    = rd_en & r_out_valid;
      // Prefetch when the stage is empty or its word leaves this cycle, so
      // back-to-back pops see no bubble.
      assign w_ram_re    = (w_ram_words != '0) & (~r_out_valid | w_rd_acc);
      assign w_empty     = ~r_out_valid;
      assign w_dout      = r_out_valid ? w_ram_q : '0;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_out_valid <= 1'b0;
        end else if (w_ram_re) begin
          r_out_valid <= 1'b1;
        end else if (w_rd_acc) begin
          r_out_valid <= 1'b0;
        end
      end
    end else begin : g_std
      // The RAM read register has no reset; dout is masked to 0 until the
      // first accepted read after reset, then holds the last word read.
      logic r_dout_valid;

      assign w_empty  = (r_count == '0);
      assign w_rd_acc = rd_en & ~w_empty;
      assign w_ram_re = w_rd_acc;
      assign w_dout   = r_dout_valid ? w_ram_q : '0;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_dout_valid <= 1'b0;
        end else if (w_rd_acc) begin
          r_dout_valid <= 1'b1;
        end
      end
    end
  endgenerate

`ifdef FIFO_ERR_FLAGS_EN
  logic r_overflow;
  logic r_underflow;

  // err_clr wins over a set in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (err_clr) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (wr_en & full) begin
        r_overflow <= 1'b1;
      end
      if (rd_en & w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`else
  logic w_unused_err_clr;

  assign w_unused_err_clr = err_clr;
  assign overflow         = 1'b0;
  assign underflow        = 1'b0;
`endif

endmodule
